// File: rtl/decode_execute_core.sv
// Decode/execute slice: opcode decoder, 32x32 register file with write-through
// bypass, ALU control and a 32-bit ALU with zero/overflow flags.
module decode_execute_core (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] instrucao,
  input  logic        sinal_escrita,
  input  logic [4:0]  reg_escrita,
  input  logic [31:0] dado_escrita,
  output logic [31:0] out_rs,
  output logic [31:0] out_rt,
  output logic [1:0]  c_ALUOp,
  output logic [1:0]  c_memoria,
  output logic [2:0]  c_desvio,
  output logic        c_fonte_ula,
  output logic        c_memtoreg,
  output logic        c_escrever_reg,
  output logic        c_reg_destino,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  alu_funct,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  output logic [2:0]  operacao,
  output logic [31:0] resultado,
  output logic        zero,
  output logic        overflow
);

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;

  logic [5:0] opcode;
  logic [4:0] rs_addr;
  logic [4:0] rt_addr;
  logic       unused_instr_bits;

  assign opcode            = instrucao[31:26];
  assign rs_addr           = instrucao[25:21];
  assign rt_addr           = instrucao[20:16];
  assign unused_instr_bits = ^instrucao[15:0];

  function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] s);
    return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] d);
    return (a[DATA_W-1] != b[DATA_W-1]) && (d[DATA_W-1] != a[DATA_W-1]);
  endfunction

  // Decode stage: control word straight from the opcode
  always_comb begin
    c_ALUOp        = 2'b00;
    c_memoria      = 2'b00;
    c_desvio       = 3'b000;
    c_fonte_ula    = 1'b0;
    c_memtoreg     = 1'b0;
    c_escrever_reg = 1'b0;
    c_reg_destino  = 1'b0;
    case (opcode)
      6'b000000: begin
        c_ALUOp        = 2'b10;
        c_escrever_reg = 1'b1;
        c_reg_destino  = 1'b1;
      end
      6'b100011: begin
        c_memoria      = 2'b01;
        c_fonte_ula    = 1'b1;
        c_memtoreg     = 1'b1;
        c_escrever_reg = 1'b1;
      end
      6'b101011: begin
        c_memoria   = 2'b10;
        c_fonte_ula = 1'b1;
      end
      6'b001000: begin
        c_fonte_ula    = 1'b1;
        c_escrever_reg = 1'b1;
      end
      6'b000100: begin
        c_ALUOp  = 2'b01;
        c_desvio = 3'b001;
      end
      6'b000101: begin
        c_ALUOp  = 2'b01;
        c_desvio = 3'b010;
      end
      6'b000010: c_desvio = 3'b011;
      6'b000011: c_desvio = 3'b100;
      default: ;
    endcase
  end

  // Register file: r0 is never written, so it stays at its reset value of 0
  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_en;

  assign wr_en = sinal_escrita && (reg_escrita != 5'd0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[reg_escrita] <= dado_escrita;
    end
  end

  // Write-through: a same-cycle write to the addressed register wins over the array
  always_comb begin
    out_rs = '0;
    if (rs_addr != 5'd0) begin
      if (wr_en && (reg_escrita == rs_addr)) out_rs = dado_escrita;
      else                                   out_rs = regs[rs_addr];
    end
  end

  always_comb begin
    out_rt = '0;
    if (rt_addr != 5'd0) begin
      if (wr_en && (reg_escrita == rt_addr)) out_rt = dado_escrita;
      else                                   out_rt = regs[rt_addr];
    end
  end

  // Execute stage: ALU control
  always_comb begin
    operacao = 3'b010;
    case (alu_op)
      2'b01: operacao = 3'b110;
      2'b10: begin
        case (alu_funct)
          6'b100010: operacao = 3'b110;
          6'b100100: operacao = 3'b000;
          6'b100101: operacao = 3'b001;
          6'b100111: operacao = 3'b100;
          6'b101010: operacao = 3'b111;
          default:   operacao = 3'b010;
        endcase
      end
      default: operacao = 3'b010;
    endcase
  end

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic signed [DATA_W-1:0] sum_s;
  logic signed [DATA_W-1:0] diff_s;

  assign a_s    = alu_a;
  assign b_s    = alu_b;
  assign sum_s  = a_s + b_s;
  assign diff_s = a_s - b_s;

  // slt uses a true signed compare, not the sign of a-b, so it survives overflow
  always_comb begin
    resultado = '0;
    overflow  = 1'b0;
    case (operacao)
      3'b000: resultado = alu_a & alu_b;
      3'b001: resultado = alu_a | alu_b;
      3'b010: begin
        resultado = sum_s;
        overflow  = add_ovf(a_s, b_s, sum_s);
      end
      3'b100: resultado = ~(alu_a | alu_b);
      3'b110: begin
        resultado = diff_s;
        overflow  = sub_ovf(a_s, b_s, diff_s);
      end
      3'b111: resultado = (a_s < b_s) ? 32'd1 : 32'd0;
      default: resultado = '0;
    endcase
  end

  assign zero = (resultado == '0);

endmodule

// File: tb/tb_decode_execute_core.sv
// Bench for decode_execute_core: directed cases plus randomized traffic
// compared against an arithmetic/table reference model.
module tb_decode_execute_core;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] instrucao;
  logic        sinal_escrita;
  logic [4:0]  reg_escrita;
  logic [31:0] dado_escrita;
  logic [31:0] out_rs, out_rt;
  logic [1:0]  c_ALUOp, c_memoria;
  logic [2:0]  c_desvio;
  logic        c_fonte_ula, c_memtoreg, c_escrever_reg, c_reg_destino;
  logic [1:0]  alu_op;
  logic [5:0]  alu_funct;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  operacao;
  logic [31:0] resultado;
  logic        zero, overflow;

  always #5 clock = ~clock;

  decode_execute_core dut (
    .clock(clock), .reset_n(reset_n), .instrucao(instrucao),
    .sinal_escrita(sinal_escrita), .reg_escrita(reg_escrita), .dado_escrita(dado_escrita),
    .out_rs(out_rs), .out_rt(out_rt),
    .c_ALUOp(c_ALUOp), .c_memoria(c_memoria), .c_desvio(c_desvio),
    .c_fonte_ula(c_fonte_ula), .c_memtoreg(c_memtoreg),
    .c_escrever_reg(c_escrever_reg), .c_reg_destino(c_reg_destino),
    .alu_op(alu_op), .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b),
    .operacao(operacao), .resultado(resultado), .zero(zero), .overflow(overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] ctrl_vec();
    return {c_ALUOp, c_memoria, c_desvio, c_fonte_ula, c_memtoreg, c_escrever_reg, c_reg_destino};
  endfunction

  // Reference decoder table: {ALUOp, memoria, desvio, fonte, memtoreg, escr, dest}
  function automatic logic [10:0] exp_ctrl(input logic [5:0] opc);
    case (opc)
      6'b000000: return 11'b10_00_000_0011;
      6'b100011: return 11'b00_01_000_1110;
      6'b101011: return 11'b00_10_000_1000;
      6'b001000: return 11'b00_00_000_1010;
      6'b000100: return 11'b01_00_001_0000;
      6'b000101: return 11'b01_00_010_0000;
      6'b000010: return 11'b00_00_011_0000;
      6'b000011: return 11'b00_00_100_0000;
      default:   return 11'b0;
    endcase
  endfunction

  function automatic logic [2:0] exp_op(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b01) return 3'b110;
    if (op != 2'b10) return 3'b010;
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b100111: return 3'b100;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // ALU model in wide signed arithmetic: overflow = true result outside 32-bit range
  task automatic alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic ov);
    longint sa, sb, s, maxv, minv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    maxv = (longint'(1) <<< 31) - 1;
    minv = -(longint'(1) <<< 31);
    ov = 1'b0;
    r  = 32'd0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b100: r = ~(a | b);
      3'b010: begin s = sa + sb; r = s[31:0]; ov = (s > maxv) || (s < minv); end
      3'b110: begin s = sa - sb; r = s[31:0]; ov = (s > maxv) || (s < minv); end
      3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
    if (sinal_escrita && reg_escrita != 5'd0 && reg_escrita == addr) return dado_escrita;
    return model[addr];
  endfunction

  task automatic check_outputs(input string tag);
    logic [31:0] r;
    logic        ov;
    logic [2:0]  op;
    op = exp_op(alu_op, alu_funct);
    alu_model(op, alu_a, alu_b, r, ov);
    check({tag, "_rs"},   out_rs,     exp_read(instrucao[25:21]));
    check({tag, "_rt"},   out_rt,     exp_read(instrucao[20:16]));
    check({tag, "_ctrl"}, ctrl_vec(), exp_ctrl(instrucao[31:26]));
    check({tag, "_op"},   operacao,   op);
    check({tag, "_res"},  resultado,  r);
    check({tag, "_zero"}, zero,       (r == 32'd0));
    check({tag, "_ovf"},  overflow,   ov);
  endtask

  // One clock edge; the model takes the same write/reset the DUT sees
  task automatic step();
    @(posedge clock);
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (sinal_escrita && reg_escrita != 5'd0) begin
      model[reg_escrita] = dado_escrita;
    end
    @(negedge clock);
  endtask

  task automatic set_alu(input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
    alu_op = op; alu_funct = f; alu_a = a; alu_b = b;
    #1;
  endtask

  logic [5:0]  dir_opc [7];
  logic [10:0] dir_vec [7];
  logic [5:0]  opc_pool [8];
  logic [5:0]  fn_pool [6];
  logic [31:0] edge_pool [6];

  initial begin
    dir_opc = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b111111};
    dir_vec = '{11'b10_00_000_0011, 11'b00_01_000_1110, 11'b00_10_000_1000,
                11'b01_00_001_0000, 11'b01_00_010_0000, 11'b00_00_011_0000, 11'b0};
    opc_pool  = '{6'h00, 6'h23, 6'h2b, 6'h08, 6'h04, 6'h05, 6'h02, 6'h03};
    fn_pool   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
    edge_pool = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0001};
    for (int i = 0; i < 32; i++) model[i] = 32'hDEAD_BEEF;

    reset_n = 1'b0; instrucao = '0; sinal_escrita = 1'b0; reg_escrita = '0;
    dado_escrita = '0; alu_op = '0; alu_funct = '0; alu_a = '0; alu_b = '0;
    @(negedge clock);
    step();
    step();
    reset_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      instrucao = {6'd0, 5'(i), 5'(31 - i), 16'd0};
      #1;
      check("reset_rs", out_rs, 32'd0);
      check("reset_rt", out_rt, 32'd0);
    end

    sinal_escrita = 1'b1;
    reg_escrita = 5'd5; dado_escrita = 32'h0000_00AA; step();
    reg_escrita = 5'd6; dado_escrita = 32'hFFFF_FFFF; step();
    reg_escrita = 5'd0; dado_escrita = 32'h0000_1234; step();
    sinal_escrita = 1'b0;
    instrucao = {6'd0, 5'd5, 5'd6, 16'd0}; #1;
    check("wr_r5", out_rs, 32'h0000_00AA);
    check("wr_r6", out_rt, 32'hFFFF_FFFF);
    instrucao = {6'd0, 5'd0, 5'd0, 16'd0}; #1;
    check("r0_rs", out_rs, 32'd0);
    check("r0_rt", out_rt, 32'd0);

    sinal_escrita = 1'b1; reg_escrita = 5'd7; dado_escrita = 32'h55;
    instrucao = {6'd0, 5'd7, 5'd5, 16'd0}; #1;
    check("bypass_rs", out_rs, 32'h55);
    check("bypass_other", out_rt, 32'h0000_00AA);
    step();
    sinal_escrita = 1'b0; #1;
    check("bypass_held", out_rs, 32'h55);

    for (int i = 0; i < 7; i++) begin
      instrucao = {dir_opc[i], 26'd0}; #1;
      check("dec_dir", ctrl_vec(), dir_vec[i]);
    end

    set_alu(2'b10, 6'b100000, 32'h7FFF_FFFF, 32'h1);
    check("add_res", resultado, 32'h8000_0000);
    check("add_ovf", overflow, 1'b1);
    set_alu(2'b10, 6'b100010, 32'd5, 32'd5);
    check("sub_res", resultado, 32'd0);
    check("sub_zero", zero, 1'b1);
    set_alu(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
    check("slt_neg", resultado, 32'd1);
    set_alu(2'b10, 6'b101010, 32'h8000_0000, 32'd1);
    check("slt_ovf", resultado, 32'd1);
    set_alu(2'b10, 6'b100100, 32'hF0F0, 32'h0FF0);
    check("and_res", resultado, 32'h0000_00F0);
    set_alu(2'b10, 6'b100101, 32'hF0F0, 32'h0FF0);
    check("or_res", resultado, 32'h0000_FFF0);
    set_alu(2'b10, 6'b100111, 32'hF0F0, 32'h0FF0);
    check("nor_res", resultado, 32'hFFFF_000F);
    check("nor_ovf", overflow, 1'b0);
    set_alu(2'b01, 6'b000000, 32'h1234, 32'h1234);
    check("beq_op", operacao, 3'b110);
    check("beq_res", resultado, 32'd0);
    check("beq_zero", zero, 1'b1);
    check("beq_ovf", overflow, 1'b0);

    sinal_escrita = 1'b1; reg_escrita = 5'd3; dado_escrita = 32'hCAFE_0003; step();
    sinal_escrita = 1'b0; instrucao = {6'd0, 5'd3, 5'd3, 16'd0}; #1;
    check("r3_written", out_rs, 32'hCAFE_0003);
    reset_n = 1'b0;
    sinal_escrita = 1'b1; reg_escrita = 5'd4; dado_escrita = 32'h4444_4444;
    step();
    reset_n = 1'b1; sinal_escrita = 1'b0;
    instrucao = {6'd0, 5'd3, 5'd4, 16'd0}; #1;
    check("r3_after_rst", out_rs, 32'd0);
    check("r4_suppressed", out_rt, 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [5:0] opc;
      opc = ($urandom_range(0, 4) == 0) ? 6'($urandom) : opc_pool[$urandom_range(0, 7)];
      instrucao     = {opc, 5'($urandom), 5'($urandom), 16'($urandom)};
      sinal_escrita = 1'($urandom_range(0, 1));
      reg_escrita   = 5'($urandom);
      dado_escrita  = $urandom;
      reset_n       = ($urandom_range(0, 59) != 0);
      alu_op        = 2'($urandom);
      alu_funct     = ($urandom_range(0, 3) != 0) ? fn_pool[$urandom_range(0, 5)] : 6'($urandom);
      alu_a = ($urandom_range(0, 2) == 0) ? edge_pool[$urandom_range(0, 5)] : $urandom;
      alu_b = ($urandom_range(0, 2) == 0) ? edge_pool[$urandom_range(0, 5)] : $urandom;
      #1;
      check_outputs("rnd");
      step();
    end
    reset_n = 1'b1;
    sinal_escrita = 1'b0;
    for (int i = 0; i < 32; i++) begin
      instrucao = {6'd0, 5'(i), 5'(i), 16'd0}; #1;
      check("final_rs", out_rs, exp_read(5'(i)));
      check("final_same", out_rt, out_rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_execute_core.md
DECODE_EXECUTE_CORE -- requirements
Module: decode_execute_core

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and the register file at 32 entries.
REQ-002 clock  in  1  single clock; all state changes on the rising edge.
REQ-003 reset_n  in  1  reset, synchronous, active-low.
REQ-004 instrucao  in  32  decode-stage instruction word: opcode [31:26], rs [25:21], rt [20:16].
REQ-005 sinal_escrita  in  1  register-file write enable (writeback stage).
REQ-006 reg_escrita  in  5  write address.
REQ-007 dado_escrita  in  32  write data.
REQ-008 out_rs, out_rt  out  32 each  read data for rs and rt.
REQ-009 c_ALUOp  out  2;  c_memoria  out  2;  c_desvio  out  3  control fields.
REQ-010 c_fonte_ula, c_memtoreg, c_escrever_reg, c_reg_destino  out  1 each  control flags.
REQ-011 alu_op  in  2;  alu_funct  in  6  execute-stage ALUOp and funct.
REQ-012 alu_a, alu_b  in  32 each  ALU operands.
REQ-013 operacao  out  3;  resultado  out  32;  zero  out  1;  overflow  out  1.

Function
REQ-014 Decoder SHALL be purely combinational on opcode; fields listed as {ALUOp, memoria, desvio, fonte_ula, memtoreg, escrever_reg, reg_destino}.
REQ-015 000000 R-type -> {10, 00, 000, 0, 0, 1, 1}.
REQ-016 100011 lw -> {00, 01, 000, 1, 1, 1, 0}; 101011 sw -> {00, 10, 000, 1, 0, 0, 0}.
REQ-017 001000 addi -> {00, 00, 000, 1, 0, 1, 0}.
REQ-018 000100 beq -> {01, 00, 001, 0, 0, 0, 0}; 000101 bne -> {01, 00, 010, 0, 0, 0, 0}.
REQ-019 000010 j -> desvio 011; 000011 jal -> desvio 100; all other fields 0.
REQ-020 Any other opcode SHALL drive all control outputs to 0 (NOP); desvio code 101 is reserved and never produced.
REQ-021 ALU control (combinational): alu_op 00 -> operacao 010 (add); 01 -> 110 (sub); 11 -> 010.
REQ-022 alu_op 10 decodes funct: 100000 -> 010 add; 100010 -> 110 sub; 100100 -> 000 and; 100101 -> 001 or; 100111 -> 100 nor; 101010 -> 111 slt; any other funct -> 010.
REQ-023 ALU (combinational): 000 a&b; 001 a|b; 010 a+b mod 2^32; 100 ~(a|b); 110 a-b mod 2^32; 111 -> 1 if signed a < signed b, else 0; codes 011/101 -> 0.
REQ-024 slt SHALL compare correctly even when a-b overflows (e.g. a=0x80000000, b=1 -> 1).
REQ-025 overflow SHALL be 1 only on signed two's-complement overflow of add (010) or sub (110); 0 for all other ops.
REQ-026 zero SHALL be 1 iff resultado == 0.
REQ-027 Register file: 32 x 32 bits; reads combinational on instrucao rs/rt.
REQ-028 Register 0 SHALL always read 0; writes to it are ignored.
REQ-029 Write: at rising clock edge with reset_n=1, sinal_escrita=1 and reg_escrita!=0, register[reg_escrita] <= dado_escrita.
REQ-030 Write-through bypass: if sinal_escrita=1, reg_escrita!=0 and reg_escrita equals rs (rt), out_rs (out_rt) SHALL show dado_escrita in the same cycle.
REQ-031 Both ports reading the same register SHALL return identical data.

Reset
REQ-032 At rising edge with reset_n=0, all 32 registers SHALL clear to 0; writes that cycle are suppressed.
REQ-033 After reset, out_rs/out_rt SHALL read 0 for every address until written; decoder and ALU outputs are combinational and unaffected by reset.
REQ-034 Reset asserted mid-operation SHALL discard all prior register contents at that edge.

Verification
REQ-035 Reset, then write r5=0x0000_00AA, r6=0xFFFF_FFFF; rs=5, rt=6 -> out_rs=0xAA, out_rt=0xFFFFFFFF; write r0=0x1234 -> r0 reads 0.
REQ-036 sinal_escrita=1, reg_escrita=7, dado=0x55 while rs=7 -> out_rs=0x55 the same cycle, before the edge.
REQ-037 Opcodes 000000, 100011, 101011, 000100, 000101, 000010, 111111 -> control vectors exactly per REQ-015..020.
REQ-038 alu_op=10: add 0x7FFFFFFF+1 -> 0x80000000, overflow=1; sub 5-5 -> 0, zero=1; slt -1<1 -> 1; and/or/nor of 0xF0F0/0x0FF0 -> 0x00F0/0xFFF0/0xFFFF000F.
REQ-039 alu_op=01 with a=b=0x1234 -> operacao=110, resultado=0, zero=1, overflow=0.
REQ-040 Write r3, assert reset_n=0 for one edge -> r3 reads 0 afterwards.
